// File: rtl/baud_rate_tx.sv
// rtl/baud_rate_tx.sv - framed NRZ baud-rate transmitter (optional PRBS7 idle via BAUD_TX_PRBS_IDLE_EN)
module baud_rate_tx #(
    parameter int          DIV_W        = 8,
    parameter int          PREAMBLE_LEN = 16,
    parameter logic [7:0]  SYNC_WORD    = 8'hD5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             sym_strobe,
    output logic             busy
);

    // Symbol index must reach both PREAMBLE_LEN and 8 (one past the last bit of a byte).
    localparam int IDX_MAX = (PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        SYNC     = 2'd2,
        DATA     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             line_d;
    logic [DIV_W-1:0] cnt_q;
    logic             load_point;
    logic             idle_bit;

`ifdef BAUD_TX_PRBS_IDLE_EN
    logic [6:0] lfsr_q;

    // PRBS7 idle generator; only moves on strobes spent in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 7'h7F;
        end else if (sym_strobe && state_q == IDLE) begin
            lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    assign idle_bit = lfsr_q[6];
`else
    assign idle_bit = 1'b0;
`endif

    // Strobe is gated by rst_n so it reads 0 while reset is held, even though cnt is 0
    assign sym_strobe = rst_n && ena && (cnt_q == '0);
    assign load_point = ((state_q == SYNC) || (state_q == DATA)) && (idx_q == IDX_W'(8));
    assign tx_ready   = sym_strobe && load_point;
    assign busy       = (state_q != IDLE);

    // Baud divider: reload on the strobe, count down on other enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            if (cnt_q == '0) begin
                cnt_q <= baud_div;
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end
    end

    // Symbol state register; everything here only changes on strobe edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_out  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_out  <= line_d;
        end
    end

    // Next-state and next-symbol selection
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        line_d  = tx_out;
        if (sym_strobe) begin
            if (load_point) begin
                if (tx_valid) begin
                    state_d = DATA;
                    shreg_d = tx_data;
                    line_d  = tx_data[7];
                    idx_d   = IDX_W'(1);
                end else begin
                    state_d = IDLE;
                    line_d  = idle_bit;
                    idx_d   = '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tx_valid) begin
                            state_d = PREAMBLE;
                            line_d  = 1'b1;
                            idx_d   = IDX_W'(1);
                        end else begin
                            line_d  = idle_bit;
                        end
                    end
                    PREAMBLE: begin
                        if (idx_q == IDX_W'(PREAMBLE_LEN)) begin
                            state_d = SYNC;
                            line_d  = SYNC_WORD[7];
                            idx_d   = IDX_W'(1);
                        end else begin
                            // Even-indexed preamble symbols are 1, odd ones 0
                            line_d  = ~idx_q[0];
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                    SYNC: begin
                        line_d = SYNC_WORD[3'd7 - idx_q[2:0]];
                        idx_d  = idx_q + IDX_W'(1);
                    end
                    DATA: begin
                        line_d = shreg_q[3'd7 - idx_q[2:0]];
                        idx_d  = idx_q + IDX_W'(1);
                    end
                    default: begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                endcase
            end
        end
    end

endmodule
